// File: rtl/line_refill_pkg.sv
// Types shared by the line refill datapath and its parent, plus the elaboration-time assert macro.
`ifndef STATIC_ASSERT
`define STATIC_ASSERT(cond, msg) if (!(cond)) begin : g_static_assert $fatal(1, msg); end
`endif

package line_refill_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } refill_state_t;

endpackage

// File: rtl/line_refill.sv
// Refills one cache line from a burst read bus into a LUTRAM line buffer, starting at the
// missed word and wrapping, and forwards the first (critical) word one cycle after it lands.
module line_refill
  import line_refill_pkg::*;
#(
  parameter int NUM_BYTES = 64
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,

  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [31:0] rd_req_addr,
  output logic [3:0]  rd_req_len,

  input  logic        rd_resp_valid,
  output logic        rd_resp_ready,
  input  logic [31:0] rd_resp_data,
  input  logic        rd_resp_last,

  output logic                                ram_en,
  output logic [$clog2(NUM_BYTES/4)-1:0]      ram_addr,
  output logic [3:0]                          ram_strobe,
  output logic [31:0]                         ram_wdata,

  output logic        crit_valid,
  output logic [31:0] crit_data,

  output logic        done,
  output logic        busy
);

  localparam int NUM_WORDS  = NUM_BYTES / 4;
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam cnt_t LAST_CNT = cnt_t'(NUM_WORDS - 1);

  `STATIC_ASSERT(NUM_BYTES == 16 || NUM_BYTES == 32 || NUM_BYTES == 64, "line_refill NUM_BYTES must be 16 32 or 64")

  refill_state_t state_q, state_d;
  logic [29:0]   word_addr_q;
  addr_t         idx_q;
  cnt_t          cnt_q;
  logic          crit_valid_q;
  word_t         crit_data_q;

  logic beat;
  logic last_beat;
  logic accept;
  logic unused_byte_bits;

  // Byte offset inside the missed word has no meaning for a word-wide bus.
  assign unused_byte_bits = ^req_addr[1:0];

  assign beat      = (state_q == FILL) && rd_resp_valid;
  assign last_beat = beat && (cnt_q == LAST_CNT);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    rd_req_valid  = 1'b0;
    rd_resp_ready = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = REQ;
      end
      REQ: begin
        rd_req_valid = 1'b1;
        if (rd_req_ready) state_d = FILL;
      end
      FILL: begin
        rd_resp_ready = 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign rd_req_addr = {word_addr_q, 2'b00};
  assign rd_req_len  = 4'(NUM_WORDS - 1);

  // Beats are never stalled, so the RAM write port follows the bus combinationally.
  assign ram_en     = beat;
  assign ram_addr   = idx_q;
  assign ram_strobe = beat ? strobe_t'(4'hF) : strobe_t'(4'h0);
  assign ram_wdata  = rd_resp_data;

  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      word_addr_q  <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      crit_valid_q <= beat && (cnt_q == '0);
      if (accept) begin
        word_addr_q <= req_addr[31:2];
        idx_q       <= req_addr[ADDR_WIDTH+1:2];
        cnt_q       <= '0;
      end
      if (beat) begin
        idx_q <= addr_t'(idx_q + 1'b1);
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == '0) crit_data_q <= rd_resp_data;
      end
    end
  end

`ifndef SYNTHESIS
  // The bus must flag exactly the final beat of the burst.
  always @(posedge clk) begin
    if (resetn && beat) begin
      assert (rd_resp_last == (cnt_q == LAST_CNT))
        else $error("line_refill: rd_resp_last does not match beat position");
    end
  end
`endif

endmodule

// File: tb/tb_line_refill.sv
// Directed bench for line_refill at NUM_BYTES=64 with hand-computed expected values.
module tb_line_refill;

  localparam int NW = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_req_addr;
  logic [3:0]  rd_req_len;
  logic        rd_resp_valid;
  logic        rd_resp_ready;
  logic [31:0] rd_resp_data;
  logic        rd_resp_last;
  logic        ram_en;
  logic [3:0]  ram_addr;
  logic [3:0]  ram_strobe;
  logic [31:0] ram_wdata;
  logic        crit_valid;
  logic [31:0] crit_data;
  logic        done;
  logic        busy;

  int errors = 0;
  int checks = 0;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          crit_n, crit_cyc, first_cyc, last_cyc, done_n, done_cyc, stray_en, rdy_seen;
  logic [31:0] crit_val;

  line_refill #(.NUM_BYTES(64)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(rd_resp_data), .rd_resp_last(rd_resp_last),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_strobe(ram_strobe), .ram_wdata(ram_wdata),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic sample(input int cyc, input bit main_phase);
    if (ram_en) begin
      wr_addr.push_back(int'(ram_addr));
      wr_data.push_back(ram_wdata);
      if (ram_strobe !== 4'hF) stray_en++;
    end
    if (ram_en && !rd_resp_valid) stray_en++;
    if (!ram_en && ram_strobe !== 4'h0) stray_en++;
    if (crit_valid) begin
      crit_n++;
      crit_cyc = cyc;
      crit_val = crit_data;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (main_phase && req_ready) rdy_seen++;
  endtask

  // Feeds beats (optionally every other cycle) and records what the DUT does, then idles 3 cycles.
  task automatic drive_beats(input int nbeats, input logic [31:0] base, input bit gap, input bit poke);
    int sent;
    int cyc;
    sent = 0; cyc = 0;
    wr_addr.delete(); wr_data.delete();
    crit_n = 0; crit_cyc = -1; first_cyc = -1; last_cyc = -1;
    done_n = 0; done_cyc = -1; stray_en = 0; rdy_seen = 0; crit_val = '0;
    while (sent < nbeats && cyc < 100) begin
      rd_resp_valid = gap ? (cyc % 2 == 0) : 1'b1;
      rd_resp_data  = base + 32'(sent);
      rd_resp_last  = rd_resp_valid && (sent == NW - 1);
      req_valid     = poke;
      #1;
      sample(cyc, 1'b1);
      if (rd_resp_valid && rd_resp_ready) begin
        if (sent == 0) first_cyc = cyc;
        last_cyc = cyc;
        sent++;
      end
      tick();
      cyc++;
    end
    rd_resp_valid = 1'b0;
    rd_resp_last  = 1'b0;
    req_valid     = 1'b0;
    repeat (3) begin
      #1;
      sample(cyc, 1'b0);
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; req_valid = 1'b0; req_addr = '0; rd_req_ready = 1'b0;
    rd_resp_valid = 1'b1; rd_resp_data = 32'h1234; rd_resp_last = 1'b0;
    tick(); tick();
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (rd_req_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_req_valid got=%b want=0", rd_req_valid); end
    checks++; if (rd_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_resp_ready got=%b want=0", rd_resp_ready); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL reset_ram_en got=%b want=0", ram_en); end
    checks++; if (ram_strobe !== 4'h0) begin errors++; $display("FAIL reset_ram_strobe got=%h want=0", ram_strobe); end
    checks++; if (crit_valid !== 1'b0) begin errors++; $display("FAIL reset_crit_valid got=%b want=0", crit_valid); end
    checks++; if (crit_data !== 32'h0) begin errors++; $display("FAIL reset_crit_data got=%h want=0", crit_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    rd_resp_valid = 1'b0;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int act;
    start_req(32'h1000_0000);
    checks++; if (rd_req_valid !== 1'b1) begin errors++; $display("FAIL basic_rd_req_valid got=%b want=1", rd_req_valid); end
    checks++; if (rd_req_addr !== 32'h1000_0000) begin errors++; $display("FAIL basic_rd_req_addr got=%h want=10000000", rd_req_addr); end
    checks++; if (rd_req_len !== 4'd15) begin errors++; $display("FAIL basic_rd_req_len got=%0d want=15", rd_req_len); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL basic_req_ready got=%b want=0", req_ready); end
    rd_req_ready = 1'b1; tick(); rd_req_ready = 1'b0;
    drive_beats(16, 32'hA0, 1'b0, 1'b0);
    checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL basic_writes got=%0d want=16", wr_addr.size()); end
    for (int i = 0; i < 16; i++) begin
      act = (i < wr_addr.size()) ? wr_addr[i] : -1;
      checks++; if (act != i) begin errors++; $display("FAIL basic_ram_addr[%0d] got=%0d want=%0d", i, act, i); end
      checks++; if (i < wr_data.size() && wr_data[i] !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL basic_wdata[%0d] got=%h want=%h", i, wr_data[i], 32'hA0 + 32'(i)); end
    end
    checks++; if (crit_n != 1) begin errors++; $display("FAIL basic_crit_count got=%0d want=1", crit_n); end
    checks++; if (crit_cyc != first_cyc + 1) begin errors++; $display("FAIL basic_crit_timing got=%0d want=%0d", crit_cyc, first_cyc + 1); end
    checks++; if (crit_val !== 32'hA0) begin errors++; $display("FAIL basic_crit_data got=%h want=a0", crit_val); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL basic_done_count got=%0d want=1", done_n); end
    checks++; if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL basic_done_timing got=%0d want=%0d", done_cyc, last_cyc + 1); end
    checks++; if (stray_en != 0) begin errors++; $display("FAIL basic_stray_writes got=%0d want=0", stray_en); end
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL basic_back_idle got=busy%b/ready%b want=busy0/ready1", busy, req_ready); end
  endtask

  task automatic test_wrap;
    int act;
    start_req(32'h1000_0034);
    checks++; if (rd_req_addr !== 32'h1000_0034) begin errors++; $display("FAIL wrap_rd_req_addr got=%h want=10000034", rd_req_addr); end
    rd_req_ready = 1'b1; tick(); rd_req_ready = 1'b0;
    drive_beats(16, 32'h5000, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      act = (i < wr_addr.size()) ? wr_addr[i] : -1;
      checks++; if (act != (13 + i) % 16) begin errors++; $display("FAIL wrap_ram_addr[%0d] got=%0d want=%0d", i, act, (13 + i) % 16); end
    end
    checks++; if (crit_val !== 32'h5000) begin errors++; $display("FAIL wrap_crit_data got=%h want=5000", crit_val); end
    checks++; if (done_n != 1 || done_cyc != last_cyc + 1) begin errors++; $display("FAIL wrap_done got=%0d@%0d want=1@%0d", done_n, done_cyc, last_cyc + 1); end
  endtask

  task automatic test_gaps;
    start_req(32'h1000_0000);
    rd_req_ready = 1'b1; tick(); rd_req_ready = 1'b0;
    drive_beats(16, 32'hC0, 1'b1, 1'b0);
    checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL gaps_writes got=%0d want=16", wr_addr.size()); end
    checks++; if (stray_en != 0) begin errors++; $display("FAIL gaps_stray_writes got=%0d want=0", stray_en); end
    checks++; if (last_cyc != 30) begin errors++; $display("FAIL gaps_last_beat_cycle got=%0d want=30", last_cyc); end
    checks++; if (crit_cyc != 1 || crit_val !== 32'hC0) begin errors++; $display("FAIL gaps_crit got=%h@%0d want=c0@1", crit_val, crit_cyc); end
    checks++; if (done_n != 1 || done_cyc != 31) begin errors++; $display("FAIL gaps_done got=%0d@%0d want=1@31", done_n, done_cyc); end
  endtask

  task automatic test_stall;
    start_req(32'h1000_0100);
    rd_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (rd_req_valid !== 1'b1 || rd_req_addr !== 32'h1000_0100) begin errors++; $display("FAIL stall_rd_req[%0d] got=%b/%h want=1/10000100", k, rd_req_valid, rd_req_addr); end
      checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stall_status[%0d] got=ready%b/busy%b want=ready0/busy1", k, req_ready, busy); end
      tick();
    end
    rd_req_ready = 1'b1; tick(); rd_req_ready = 1'b0;
    drive_beats(16, 32'hD0, 1'b0, 1'b0);
    checks++; if (wr_addr.size() != 16 || done_n != 1) begin errors++; $display("FAIL stall_complete got=writes%0d/done%0d want=writes16/done1", wr_addr.size(), done_n); end
  endtask

  task automatic test_reset_mid;
    int act;
    start_req(32'h1000_0040);
    rd_req_ready = 1'b1; tick(); rd_req_ready = 1'b0;
    drive_beats(7, 32'hE0, 1'b0, 1'b0);
    checks++; if (wr_addr.size() != 7 || done_n != 0) begin errors++; $display("FAIL rmid_partial got=writes%0d/done%0d want=writes7/done0", wr_addr.size(), done_n); end
    resetn = 1'b0; rd_resp_valid = 1'b1; rd_resp_data = 32'hDEAD;
    tick();
    #1;
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_status got=ready%b/busy%b want=ready1/busy0", req_ready, busy); end
    checks++; if (rd_req_valid !== 1'b0 || rd_resp_ready !== 1'b0) begin errors++; $display("FAIL rmid_handshakes got=%b/%b want=0/0", rd_req_valid, rd_resp_ready); end
    checks++; if (ram_en !== 1'b0 || ram_strobe !== 4'h0) begin errors++; $display("FAIL rmid_ram got=en%b/strb%h want=en0/strb0", ram_en, ram_strobe); end
    checks++; if (crit_valid !== 1'b0 || crit_data !== 32'h0 || done !== 1'b0) begin errors++; $display("FAIL rmid_outputs got=cv%b/cd%h/done%b want=0/0/0", crit_valid, crit_data, done); end
    rd_resp_valid = 1'b0;
    resetn = 1'b1;
    tick();
    start_req(32'h2000_0008);
    checks++; if (rd_req_addr !== 32'h2000_0008) begin errors++; $display("FAIL rmid_new_addr got=%h want=20000008", rd_req_addr); end
    rd_req_ready = 1'b1; tick(); rd_req_ready = 1'b0;
    drive_beats(16, 32'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      act = (i < wr_addr.size()) ? wr_addr[i] : -1;
      checks++; if (act != (2 + i) % 16) begin errors++; $display("FAIL rmid_ram_addr[%0d] got=%0d want=%0d", i, act, (2 + i) % 16); end
    end
    checks++; if (crit_val !== 32'hF0 || done_n != 1) begin errors++; $display("FAIL rmid_new_fill got=crit%h/done%0d want=critf0/done1", crit_val, done_n); end
  endtask

  task automatic test_req_during_fill;
    start_req(32'h1000_0000);
    rd_req_ready = 1'b1; tick(); rd_req_ready = 1'b0;
    req_addr = 32'h3000_0000;
    drive_beats(16, 32'h11, 1'b0, 1'b1);
    checks++; if (rdy_seen != 0) begin errors++; $display("FAIL busyreq_req_ready got=%0d want=0", rdy_seen); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL busyreq_done_count got=%0d want=1", done_n); end
    checks++; if (busy !== 1'b0 || rd_req_valid !== 1'b0) begin errors++; $display("FAIL busyreq_no_second got=busy%b/rdreq%b want=0/0", busy, rd_req_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_gaps();
    test_stall();
    test_reset_mid();
    test_req_during_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/line_refill.md
LINE_REFILL -- requirements
Module: line_refill

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 64, giving the line size in bytes; legal values are 16, 32 and 64.
REQ-002 SHALL derive localparams NUM_WORDS = NUM_BYTES/4 and ADDR_WIDTH = $clog2(NUM_WORDS), giving 2, 3 or 4 bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have ports req_valid (input, 1), req_ready (output, 1) and req_addr (input, 32): the miss request handshake and the byte address.
REQ-006 SHALL have ports rd_req_valid (output, 1), rd_req_ready (input, 1), rd_req_addr (output, 32) and rd_req_len (output, 4): the bus burst request; len = beats-1.
REQ-007 SHALL have ports rd_resp_valid (input, 1), rd_resp_ready (output, 1), rd_resp_data (input, 32) and rd_resp_last (input, 1): the bus read beats.
REQ-008 SHALL have ports ram_en (output, 1), ram_addr (output, ADDR_WIDTH), ram_strobe (output, 4) and ram_wdata (output, 32): the write port of the downstream LUTRAM line buffer.
REQ-009 SHALL have ports crit_valid (output, 1) and crit_data (output, 32): the critical-word forward.
REQ-010 SHALL have ports done (output, 1), a line-complete pulse, and busy (output, 1).

Function
REQ-011 SHALL implement the FSM states IDLE, REQ, FILL and DONE.
REQ-012 SHALL drive req_ready = (state==IDLE); accept a request on req_valid&&req_ready; capture word offset req_addr[ADDR_WIDTH+1:2]; move to REQ.
REQ-013 SHALL, in REQ, hold rd_req_valid=1, rd_req_addr={req_addr[31:2],2'b00} and rd_req_len=NUM_WORDS-1 stable until rd_req_ready, then move to FILL.
REQ-014 SHALL, in FILL, drive rd_resp_ready=1; each accepted beat combinationally drives ram_en=1, ram_strobe=4'hF, ram_wdata=rd_resp_data and ram_addr=current index.
REQ-015 SHALL start the index at the captured offset and increment it by 1 per accepted beat, wrapping modulo NUM_WORDS (natural ADDR_WIDTH overflow).
REQ-016 SHALL count accepted beats; on acceptance of beat NUM_WORDS it moves to DONE.
REQ-017 SHALL never stall beats; ram_en SHALL be 0 in every cycle without an accepted beat.
REQ-018 SHALL, in the cycle after the first beat is accepted, assert crit_valid=1 for exactly one cycle with crit_data equal to that beat's data (registered).
REQ-019 SHALL, in DONE, assert done=1 for one cycle and then return to IDLE.
REQ-020 SHALL assert busy whenever state!=IDLE.
REQ-021 SHALL ignore req_valid outside IDLE.
REQ-022 SHALL, in simulation only, flag an assertion failure if rd_resp_last is 1 on any beat but beat NUM_WORDS, or 0 on beat NUM_WORDS; this SHALL NOT alter behaviour.
REQ-023 SHALL ignore rd_resp_valid outside FILL and hold rd_resp_ready=0 there.

Reset
REQ-024 SHALL, on resetn=0 at a clock edge, enter IDLE with index, beat count and crit_data cleared to 0.
REQ-025 SHALL drive these values while in reset: req_ready=1 after reset; rd_req_valid, rd_resp_ready, ram_en, crit_valid, done and busy = 0; ram_strobe=0; rd_req_addr, ram_addr and ram_wdata don't-care.
REQ-026 SHALL, on reset mid-operation, abandon the refill with no done pulse; partially written RAM contents are undefined; the parent is responsible for any outstanding bus beats.

Structure
REQ-027 SHALL place word_t (32 bits), strobe_t (4 bits) and refill_state_t (the FSM enum) in the shared common package.
REQ-028 SHALL derive addr_t from ADDR_WIDTH locally.
REQ-029 SHALL use no sub-module; the parent instantiates the LUTRAM and connects ram_* to its addr/strobe/wdata/en ports.
REQ-030 SHALL check NUM_BYTES legality with the codebase's static assert macro.

Verification (NUM_BYTES=64)
REQ-031 SHALL cover: req_addr=0x10000000, rd_req_ready=1, 16 back-to-back beats data=0xA0+i -> rd_req_addr=0x10000000, len=15, ram_addr 0..15, crit_data=0xA0 one cycle after beat 0, done the cycle after DONE entry.
REQ-032 SHALL cover: req_addr=0x10000034 -> offset 13, ram_addr sequence 13,14,15,0..12, crit_data = first beat data, done after 16 beats.
REQ-033 SHALL cover: rd_resp_valid toggling every other cycle -> ram_en only on valid cycles, exactly 16 writes, done after the 16th accepted beat.
REQ-034 SHALL cover: rd_req_ready held 0 for 5 cycles -> rd_req_valid and rd_req_addr stable, req_ready=0, busy=1 throughout.
REQ-035 SHALL cover: resetn=0 after 7 beats -> all outputs at reset values, no done; a following request at 0x20000008 completes normally.
REQ-036 SHALL cover: req_valid=1 during FILL -> not accepted; exactly one done for the original request.
